// File: rtl/wvb_readout_arbiter_pkg.sv
// Shared definitions for the waveform-buffer readout arbiter: beat field
// widths, end-of-event bit position, truncation length and FSM state type.
package wvb_readout_arbiter_pkg;

  localparam int WVB_N_CHAN     = 24;
  localparam int WVB_CHAN_WIDTH = 5;
  localparam int WVB_DATA_WIDTH = 22;
  localparam int WVB_HDR_WIDTH  = 80;
  localparam int WVB_EOE_BIT    = 0;
  localparam int WVB_MAX_LEN    = 4096;
  localparam int WVB_CNT_WIDTH  = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } wvb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority picker: first requester strictly after ptr, wrapping.
// Purely combinational so it can be shared by other arbiters.
module rr_priority_select #(
  parameter int P_N = 24,
  parameter int P_W = 5
) (
  input  logic [P_N-1:0] req,
  input  logic [P_W-1:0] ptr,
  output logic [P_N-1:0] grant_oh,
  output logic [P_W-1:0] grant_idx,
  output logic           any
);

  int unsigned k;

  // Scan ptr+1, ptr+2, ... modulo P_N and keep the first hit
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = 0;
    for (int unsigned i = 1; i <= P_N; i++) begin
      k = (32'(ptr) + i) % P_N;
      if (!any && req[k]) begin
        any         = 1'b1;
        grant_oh[k] = 1'b1;
        grant_idx   = P_W'(k);
      end
    end
  end

endmodule

// File: rtl/wvb_readout_arbiter.sv
// Shares one valid/ready readout stream among the per-PMT waveform buffers.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | wait for en and an eligible pending header; latch RR grant
//   HDR     | emit header beat, pop granted header FIFO
//   DATA    | emit one sample per free slot until EOE or length limit
//   DONE    | pulse rddone to granted buffer, advance RR pointer
module wvb_readout_arbiter
  import wvb_readout_arbiter_pkg::*;
#(
  parameter int P_N_CHAN     = WVB_N_CHAN,
  parameter int P_CHAN_WIDTH = WVB_CHAN_WIDTH,
  parameter int P_DATA_WIDTH = WVB_DATA_WIDTH,
  parameter int P_HDR_WIDTH  = WVB_HDR_WIDTH,
  parameter int P_EOE_BIT    = WVB_EOE_BIT,
  parameter int P_MAX_LEN    = WVB_MAX_LEN,
  parameter int P_CNT_WIDTH  = WVB_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [P_N_CHAN-1:0]             chan_mask,
  input  logic [P_N_CHAN-1:0]             hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0] hdr_data,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_N_CHAN-1:0]             hdr_rdreq,
  output logic [P_N_CHAN-1:0]             wvb_rdreq,
  output logic [P_N_CHAN-1:0]             wvb_rddone,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic                            out_trunc,
  output logic [P_CHAN_WIDTH-1:0]         out_chan,
  output logic [P_HDR_WIDTH-1:0]          out_hdr,
  output logic [P_DATA_WIDTH-1:0]         out_data,
  output logic                            busy
);

  wvb_state_t                state_q, state_d;
  logic [P_CHAN_WIDTH-1:0]   ptr_q, grant_q;
  logic [P_N_CHAN-1:0]       grant_oh_q;
  logic [P_CNT_WIDTH-1:0]    cnt_q;

  logic [P_N_CHAN-1:0]       req, sel_oh;
  logic [P_CHAN_WIDTH-1:0]   sel_idx;
  logic                      sel_any;
  logic                      slot_free, load_hdr, load_data, eoe, last_beat;
  logic [P_HDR_WIDTH-1:0]    hdr_sel;
  logic [P_DATA_WIDTH-1:0]   smp_sel;

  assign req       = ~hdr_empty & chan_mask;
  assign slot_free = !out_valid || out_ready;
  assign hdr_sel   = hdr_data[int'(grant_q)*P_HDR_WIDTH +: P_HDR_WIDTH];
  assign smp_sel   = wvb_data[int'(grant_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign eoe       = smp_sel[P_EOE_BIT];
  // cnt_q still holds the count before this beat, so this is beat P_MAX_LEN
  assign last_beat = eoe || (cnt_q == P_CNT_WIDTH'(P_MAX_LEN - 1));
  assign busy      = (state_q != ST_IDLE);

  rr_priority_select #(
    .P_N (P_N_CHAN),
    .P_W (P_CHAN_WIDTH)
  ) u_rr_sel (
    .req       (req),
    .ptr       (ptr_q),
    .grant_oh  (sel_oh),
    .grant_idx (sel_idx),
    .any       (sel_any)
  );

  // Next state and the single-cycle buffer strobes, gated by output slot
  always_comb begin
    state_d    = state_q;
    load_hdr   = 1'b0;
    load_data  = 1'b0;
    hdr_rdreq  = '0;
    wvb_rdreq  = '0;
    wvb_rddone = '0;
    case (state_q)
      ST_IDLE: begin
        if (en && sel_any) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (slot_free) begin
          load_hdr  = 1'b1;
          hdr_rdreq = grant_oh_q;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (slot_free) begin
          load_data = 1'b1;
          wvb_rdreq = grant_oh_q;
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        wvb_rddone = grant_oh_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched grant, RR pointer and per-waveform beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= P_CHAN_WIDTH'(P_N_CHAN - 1);
      grant_q    <= '0;
      grant_oh_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && en && sel_any) begin
        grant_q    <= sel_idx;
        grant_oh_q <= sel_oh;
      end
      if (load_hdr) cnt_q <= '0;
      else if (load_data) cnt_q <= cnt_q + P_CNT_WIDTH'(1);
      if (state_q == ST_DONE) ptr_q <= grant_q;
    end
  end

  // Output beat register: load on a free slot, otherwise drain on ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_trunc <= 1'b0;
      out_chan  <= '0;
      out_hdr   <= '0;
      out_data  <= '0;
    end else if (load_hdr) begin
      out_valid <= 1'b1;
      out_sop   <= 1'b1;
      out_eop   <= 1'b0;
      out_trunc <= 1'b0;
      out_chan  <= grant_q;
      out_hdr   <= hdr_sel;
      out_data  <= '0;
    end else if (load_data) begin
      out_valid <= 1'b1;
      out_sop   <= 1'b0;
      out_eop   <= last_beat;
      out_trunc <= last_beat && !eoe;
      out_chan  <= grant_q;
      out_data  <= smp_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// Randomised scoreboard bench for wvb_readout_arbiter with a behavioural
// buffer model and a queue-based round-robin reference.
module tb_wvb_readout_arbiter;

  localparam int N    = 24;
  localparam int CW   = 5;
  localparam int DW   = 22;
  localparam int HW   = 80;
  localparam int ML   = 16;
  localparam int NWF  = 512;
  localparam int NS   = 24;
  localparam int NEXP = 8192;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic          trunc;
    logic [CW-1:0] chan;
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
  } beat_t;

  logic              clk, rst_n, en, out_ready;
  logic [N-1:0]      chan_mask, hdr_empty, hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic [N*HW-1:0]   hdr_data;
  logic [N*DW-1:0]   wvb_data;
  logic              out_valid, out_sop, out_eop, out_trunc, busy;
  logic [CW-1:0]     out_chan;
  logic [HW-1:0]     out_hdr;
  logic [DW-1:0]     out_data;

  int total = 0;
  int bad   = 0;

  // waveform stimulus storage
  logic [HW-1:0] wf_hdr [NWF];
  logic [DW-1:0] wf_smp [NWF][NS];
  int            wf_chan[NWF];
  int            n_wf = 0;

  // main -> buffer model handoff (single writer per index)
  int add_id[NWF];
  int add_wr    = 0;
  int flush_cnt = 0;
  int rdy_mode  = 0;

  // scoreboard
  beat_t exp_mem[NEXP];
  int    exp_wr    = 0;
  int    exp_rd    = 0;
  int    exp_skip  = 0;
  int    dbeat_cnt = 0;

  // buffer-side strobe counters
  int cnt_hdr = 0, cnt_wvb = 0, cnt_done = 0;

  // reference model
  int mdl_pend[N][$];
  int mdl_ptr = N - 1;
  int exp_h, exp_w, exp_d, snap_h, snap_w, snap_d;

  wvb_readout_arbiter #(.P_MAX_LEN(ML)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .chan_mask  (chan_mask),
    .hdr_empty  (hdr_empty),
    .hdr_data   (hdr_data),
    .wvb_data   (wvb_data),
    .hdr_rdreq  (hdr_rdreq),
    .wvb_rdreq  (wvb_rdreq),
    .wvb_rddone (wvb_rddone),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_trunc  (out_trunc),
    .out_chan   (out_chan),
    .out_hdr    (out_hdr),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string name, input string got, input string want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  // data beats a waveform should produce: up to and including EOE, capped at ML
  function automatic int exp_nbeats(input int id);
    for (int i = 0; i < ML; i++)
      if (wf_smp[id][i][0]) return i + 1;
    return ML;
  endfunction

  function automatic int exp_left();
    int rd;
    rd = (exp_rd > exp_skip) ? exp_rd : exp_skip;
    return exp_wr - rd;
  endfunction

  task automatic new_wf(input int ch, input int len, input bit eoe, output int id);
    logic [95:0] h;
    logic [31:0] r;
    id = n_wf;
    n_wf++;
    h = {$urandom(), $urandom(), $urandom()};
    wf_hdr[id]  = h[HW-1:0];
    wf_chan[id] = ch;
    for (int i = 0; i < NS; i++) begin
      r = $urandom();
      wf_smp[id][i]    = r[DW-1:0];
      wf_smp[id][i][0] = eoe && (i == len - 1);
    end
  endtask

  task automatic issue(input int id);
    add_id[add_wr] = id;
    add_wr++;
    mdl_pend[wf_chan[id]].push_back(id);
  endtask

  task automatic push_exp(input beat_t b);
    exp_mem[exp_wr] = b;
    exp_wr++;
  endtask

  // Serve every eligible pending waveform in round-robin order from mdl_ptr
  task automatic predict(input logic [N-1:0] mask);
    int pick, id, nb, c;
    beat_t b;
    forever begin
      pick = -1;
      for (int i = 1; i <= N; i++) begin
        c = (mdl_ptr + i) % N;
        if (pick < 0 && mask[c] && mdl_pend[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      id = mdl_pend[pick].pop_front();
      mdl_ptr = pick;
      b = '0;
      b.sop  = 1'b1;
      b.chan = CW'(pick);
      b.hdr  = wf_hdr[id];
      push_exp(b);
      nb = exp_nbeats(id);
      for (int j = 0; j < nb; j++) begin
        b = '0;
        b.chan  = CW'(pick);
        b.data  = wf_smp[id][j];
        b.eop   = (j == nb - 1);
        b.trunc = (j == nb - 1) && !wf_smp[id][j][0];
        push_exp(b);
      end
      exp_h++;
      exp_w += nb;
      exp_d++;
    end
  endtask

  task automatic begin_batch();
    snap_h = cnt_hdr;
    snap_w = cnt_wvb;
    snap_d = cnt_done;
    exp_h = 0;
    exp_w = 0;
    exp_d = 0;
  endtask

  task automatic start_batch(input logic [N-1:0] mask, input int mode);
    @(posedge clk); #2;
    chan_mask = mask;
    rdy_mode  = mode;
    predict(mask);
    en = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      if (exp_left() == 0 && !busy && !out_valid) done = 1'b1;
    end
    chk(done, {name, "_drain"}, $sformatf("left=%0d busy=%0b", exp_left(), busy), "left=0 busy=0");
    chk(cnt_hdr - snap_h == exp_h, {name, "_hdr_rdreq"}, $sformatf("%0d", cnt_hdr - snap_h), $sformatf("%0d", exp_h));
    chk(cnt_wvb - snap_w == exp_w, {name, "_wvb_rdreq"}, $sformatf("%0d", cnt_wvb - snap_w), $sformatf("%0d", exp_w));
    chk(cnt_done - snap_d == exp_d, {name, "_rddone"}, $sformatf("%0d", cnt_done - snap_d), $sformatf("%0d", exp_d));
    @(posedge clk); #2;
    en = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    chk(seen, name, "busy=0", "busy=1");
  endtask

  task automatic flush_model();
    flush_cnt++;
    exp_skip = exp_wr;
    for (int c = 0; c < N; c++) mdl_pend[c].delete();
    mdl_ptr = N - 1;
  endtask

  // Buffer model: show-ahead header/sample per channel, reacts to strobes
  initial begin : bus
    int buf_q[N][$];
    int active[N];
    int act_idx[N];
    int ph, pw, pd, nb, add_rd, flush_seen;
    logic [N-1:0] pulses;
    add_rd = 0;
    flush_seen = 0;
    out_ready = 1'b1;
    hdr_empty = '1;
    hdr_data  = '0;
    wvb_data  = '0;
    for (int c = 0; c < N; c++) begin
      active[c] = -1;
      act_idx[c] = 0;
    end
    forever begin
      @(negedge clk);
      ph = -1;
      pw = -1;
      pd = -1;
      if (rst_n) begin
        pulses = hdr_rdreq | wvb_rdreq | wvb_rddone;
        if (pulses != '0)
          chk($onehot(pulses), "strobe_onehot", $sformatf("%h", pulses), "one bit");
        if ((hdr_rdreq | wvb_rdreq) != '0)
          chk(!out_valid || out_ready, "pop_slot_free", $sformatf("valid=%0b ready=%0b", out_valid, out_ready), "slot free");
        for (int c = 0; c < N; c++) begin
          if (hdr_rdreq[c]) begin
            chk(buf_q[c].size() > 0 && active[c] < 0, "hdr_pop_src", $sformatf("ch%0d depth=%0d", c, buf_q[c].size()), "pending idle channel");
            ph = c;
            cnt_hdr++;
          end
          if (wvb_rdreq[c]) begin
            chk(active[c] >= 0, "wvb_pop_src", $sformatf("ch%0d inactive", c), "active channel");
            pw = c;
            cnt_wvb++;
          end
          if (wvb_rddone[c]) begin
            nb = (active[c] >= 0) ? exp_nbeats(active[c]) : -1;
            chk(active[c] >= 0 && act_idx[c] == nb, "rddone_len", $sformatf("ch%0d samples=%0d", c, act_idx[c]), $sformatf("%0d", nb));
            pd = c;
            cnt_done++;
          end
        end
      end
      @(posedge clk); #1;
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        for (int c = 0; c < N; c++) begin
          buf_q[c].delete();
          active[c] = -1;
          act_idx[c] = 0;
        end
      end else begin
        if (ph >= 0) begin
          if (buf_q[ph].size() > 0) active[ph] = buf_q[ph].pop_front();
          act_idx[ph] = 0;
        end
        if (pw >= 0 && act_idx[pw] < NS - 1) act_idx[pw]++;
        if (pd >= 0) active[pd] = -1;
      end
      while (add_rd < add_wr) begin
        buf_q[wf_chan[add_id[add_rd]]].push_back(add_id[add_rd]);
        add_rd++;
      end
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !out_ready;
        default: out_ready = 1'b1;
      endcase
      for (int c = 0; c < N; c++) begin
        hdr_empty[c] = (buf_q[c].size() == 0);
        hdr_data[c*HW +: HW] = (buf_q[c].size() > 0) ? wf_hdr[buf_q[c][0]] : '0;
        wvb_data[c*DW +: DW] = (active[c] >= 0) ? wf_smp[active[c]][act_idx[c]] : '0;
      end
    end
  end

  // Monitor: compare every accepted beat against the expected queue
  initial begin : monitor
    beat_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_rd < exp_skip) exp_rd = exp_skip;
        if (exp_rd >= exp_wr) begin
          chk(1'b0, "unexpected_beat", $sformatf("sop%0b ch%0d d%0h", out_sop, out_chan, out_data), "no beat");
        end else begin
          e = exp_mem[exp_rd];
          exp_rd++;
          ok = (out_sop == e.sop) && (out_eop == e.eop) && (out_trunc == e.trunc) &&
               (out_chan == e.chan) && (out_data == e.data) && (!e.sop || out_hdr == e.hdr);
          chk(ok, "beat",
              $sformatf("sop%0b eop%0b tr%0b ch%0d d%0h h%0h", out_sop, out_eop, out_trunc, out_chan, out_data, out_hdr),
              $sformatf("sop%0b eop%0b tr%0b ch%0d d%0h h%0h", e.sop, e.eop, e.trunc, e.chan, e.data, e.hdr));
        end
        if (!out_sop) dbeat_cnt++;
      end
    end
  end

  initial begin : main
    int id, nwf, ch, r, d0;
    bit hit;
    logic [N-1:0] m;
    rst_n = 1'b0;
    en = 1'b0;
    chan_mask = '1;
    repeat (3) @(posedge clk);
    #2;
    chk(!out_valid && !busy, "reset_state", $sformatf("valid=%0b busy=%0b", out_valid, busy), "0 0");
    chk((hdr_rdreq | wvb_rdreq | wvb_rddone) == '0 && !out_sop && !out_eop && out_chan == '0,
        "reset_outputs", $sformatf("strobes=%h sop=%0b ch=%0d", hdr_rdreq | wvb_rdreq | wvb_rddone, out_sop, out_chan), "all 0");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // ch3, 3 samples, header latency from hdr_empty falling
    begin_batch();
    @(posedge clk); #2;
    chan_mask = '1;
    rdy_mode = 0;
    en = 1'b1;
    new_wf(3, 3, 1'b1, id);
    issue(id);
    predict('1);
    @(posedge clk); #2;
    @(negedge clk);
    @(negedge clk);
    chk(!out_valid, "hdr_latency_early", $sformatf("valid=%0b", out_valid), "0");
    @(negedge clk);
    chk(out_valid && out_sop && out_chan == 5'd3, "hdr_latency", $sformatf("valid=%0b sop=%0b ch=%0d", out_valid, out_sop, out_chan), "1 1 3");
    drain("ch3_basic");

    // fairness: ch0 and ch5 twice each from reset pointer
    @(posedge clk); #2;
    rst_n = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    begin_batch();
    for (int k = 0; k < 2; k++) begin
      new_wf(0, $urandom_range(1, 6), 1'b1, id);
      issue(id);
      new_wf(5, $urandom_range(1, 6), 1'b1, id);
      issue(id);
    end
    start_batch('1, 0);
    drain("rr_0_5");

    // 1010 backpressure on an 8-sample waveform, en dropped mid-waveform
    begin_batch();
    new_wf(11, 8, 1'b1, id);
    issue(id);
    start_batch('1, 2);
    wait_busy("toggle_busy");
    en = 1'b0;
    drain("toggle_8");

    // truncation and length-limit boundaries
    begin_batch();
    new_wf(7, 20, 1'b0, id);
    issue(id);
    new_wf(9, ML, 1'b1, id);
    issue(id);
    new_wf(12, 20, 1'b1, id);
    issue(id);
    start_batch('1, 1);
    drain("trunc");

    // channel mask gating
    begin_batch();
    new_wf(2, 10, 1'b1, id);
    issue(id);
    start_batch(~(N'(1) << 2), 0);
    repeat (20) @(negedge clk);
    chk(!busy && cnt_hdr == snap_h, "mask_block", $sformatf("busy=%0b pops=%0d", busy, cnt_hdr - snap_h), "idle 0");
    @(posedge clk); #2;
    chan_mask[2] = 1'b1;
    predict(chan_mask);
    wait_busy("mask_busy");
    repeat (3) @(posedge clk);
    #2;
    chan_mask[2] = 1'b0;
    drain("mask");

    // async reset mid-waveform, then ch0 must win over ch20
    begin_batch();
    new_wf(4, 12, 1'b1, id);
    issue(id);
    start_batch('1, 0);
    d0 = dbeat_cnt;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (dbeat_cnt >= d0 + 3);
    end
    chk(hit, "rst_wait", $sformatf("beats=%0d", dbeat_cnt - d0), ">=3");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk(!out_valid && !busy, "rst_async_out", $sformatf("valid=%0b busy=%0b", out_valid, busy), "0 0");
    chk((hdr_rdreq | wvb_rdreq | wvb_rddone) == '0, "rst_async_strobe", $sformatf("%h", hdr_rdreq | wvb_rdreq | wvb_rddone), "0");
    flush_model();
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    begin_batch();
    new_wf(20, 4, 1'b1, id);
    issue(id);
    new_wf(0, 4, 1'b1, id);
    issue(id);
    start_batch('1, 0);
    drain("post_rst");

    // random batches with random masks and backpressure
    for (int b = 0; b < 25; b++) begin
      begin_batch();
      nwf = $urandom_range(1, 6);
      for (int k = 0; k < nwf; k++) begin
        ch = $urandom_range(0, N - 1);
        r = $urandom_range(0, 9);
        if (r < 7)       new_wf(ch, $urandom_range(1, ML - 1), 1'b1, id);
        else if (r == 7) new_wf(ch, ML, 1'b1, id);
        else if (r == 8) new_wf(ch, $urandom_range(ML + 1, NS - 2), 1'b1, id);
        else             new_wf(ch, ML, 1'b0, id);
        issue(id);
      end
      m = N'({$urandom(), $urandom()} | {$urandom(), $urandom()});
      if (b == 24) m = '1;
      start_batch(m, $urandom_range(0, 1));
      drain("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
